// File: rtl/hwpe_stream_zero_source_if.sv
// hwpe_stream_intf_stream: valid/ready stream bundle with a zeroing-friendly layout.
// source is the driving (master) side, sink the receiving (slave) side, and
// monitor is a read-only tap used by shadow and checking logic.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );

    modport monitor (
        input valid, data, strb, ready
    );

endinterface

// File: rtl/hwpe_stream_zero_source.sv
// hwpe_stream_zero_source: drives an all-zero shadow copy of a stream into the
// zero network and flags any cycle in which the shadow's ready disagrees with
// the real stream's ready. Fault state is sticky until clear_i.
//
// Optional feature: define HWPE_STREAM_ZERO_SOURCE_WATCHDOG_EN to add a stall
// watchdog that faults after STALL_TIMEOUT consecutive valid-without-ready cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISABLED | checking off, no detection or counting
// MONITOR  | comparing readys each cycle, no fault seen yet
// FAULTED  | fault seen; keeps counting mismatches until clear_i
module hwpe_stream_zero_source #(
    parameter int unsigned CNT_WIDTH     = 8,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   enable_i,
    hwpe_stream_intf_stream.monitor normal_i,
    hwpe_stream_intf_stream.source  zero_o,
    output logic                   fault_detected_o,
    output logic                   fault_sticky_o,
    output logic [CNT_WIDTH-1:0]   fault_count_o,
    output logic                   stall_timeout_o
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        MONITOR  = 2'd1,
        FAULTED  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q;
    logic                 fault_detected_q;
    logic                 fault_sticky_q;
    logic [CNT_WIDTH-1:0] fault_count_q;

    logic mismatch;
    logic active;
    logic stall_hit;
    logic unused_data;

    // Shadow stream: same valid/strb as the real stream, payload forced to zero.
    assign zero_o.valid = normal_i.valid;
    assign zero_o.strb  = normal_i.strb;
    assign zero_o.data  = '0;

    // Payload is never inspected; only the handshake is compared.
    assign unused_data = ^normal_i.data;

    assign mismatch = (zero_o.ready != normal_i.ready);
    assign active   = (state_q != DISABLED);

`ifdef HWPE_STREAM_ZERO_SOURCE_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;
    logic            stall_q;
    logic            stalled;

    assign stalled = active && normal_i.valid && !normal_i.ready;

    // Consecutive-stall counter; any handshake, idle cycle or clear restarts it.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clear_i || !stalled) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_LIMIT) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    assign stall_hit = stalled && !clear_i && (wd_cnt_d == WD_LIMIT);

    // Watchdog count register and sticky stall flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (clear_i) begin
                stall_q <= 1'b0;
            end else if (stall_hit) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign stall_timeout_o = stall_q;
`else
    logic unused_param;

    assign unused_param    = (STALL_TIMEOUT != 0);
    assign stall_hit       = 1'b0;
    assign stall_timeout_o = 1'b0;
`endif

    // Checker FSM with registered fault outputs; clear_i wins over a same-cycle fault.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= DISABLED;
            fault_detected_q <= 1'b0;
            fault_sticky_q   <= 1'b0;
            fault_count_q    <= '0;
        end else begin
            // Per-cycle flag ignores clear_i so it always reflects the last cycle.
            fault_detected_q <= active && mismatch;

            if (clear_i) begin
                state_q        <= DISABLED;
                fault_sticky_q <= 1'b0;
                fault_count_q  <= '0;
            end else begin
                if (active && mismatch && (fault_count_q != CNT_MAX)) begin
                    fault_count_q <= fault_count_q + 1'b1;
                end
                if (active && (mismatch || stall_hit)) begin
                    fault_sticky_q <= 1'b1;
                end
                case (state_q)
                    DISABLED: begin
                        if (enable_i) begin
                            state_q <= MONITOR;
                        end
                    end
                    MONITOR: begin
                        if (mismatch || stall_hit) begin
                            state_q <= FAULTED;
                        end else if (!enable_i) begin
                            state_q <= DISABLED;
                        end
                    end
                    FAULTED: begin
                        state_q <= FAULTED;
                    end
                    default: begin
                        state_q <= DISABLED;
                    end
                endcase
            end
        end
    end

    assign fault_detected_o = fault_detected_q;
    assign fault_sticky_o   = fault_sticky_q;
    assign fault_count_o    = fault_count_q;

endmodule

// File: tb/tb_hwpe_stream_zero_source.sv
// Directed bench for hwpe_stream_zero_source. Two instances share the stimulus:
// dut_a with an 8-bit counter and dut_b with a 2-bit counter (saturation case),
// both with a 4-cycle stall timeout. Expectations adapt to the watchdog build.
module tb_hwpe_stream_zero_source;

`ifdef HWPE_STREAM_ZERO_SOURCE_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;

    logic       det_a, stk_a, st_a;
    logic [7:0] cnt_a;
    logic       det_b, stk_b, st_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int failures = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) normal ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zero_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) zero_b ();

    always #5 clk = ~clk;

    hwpe_stream_zero_source #(.CNT_WIDTH(8), .STALL_TIMEOUT(4)) dut_a (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .enable_i         (enable),
        .normal_i         (normal),
        .zero_o           (zero_a),
        .fault_detected_o (det_a),
        .fault_sticky_o   (stk_a),
        .fault_count_o    (cnt_a),
        .stall_timeout_o  (st_a)
    );

    hwpe_stream_zero_source #(.CNT_WIDTH(2), .STALL_TIMEOUT(4)) dut_b (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .enable_i         (enable),
        .normal_i         (normal),
        .zero_o           (zero_b),
        .fault_detected_o (det_b),
        .fault_sticky_o   (stk_b),
        .fault_count_o    (cnt_b),
        .stall_timeout_o  (st_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_io(input logic v, input logic n_rdy, input logic z_rdy);
        normal.valid = v;
        normal.ready = n_rdy;
        zero_a.ready = z_rdy;
        zero_b.ready = z_rdy;
    endtask

    initial begin
        set_io(1'b1, 1'b1, 1'b1);
        normal.strb = 4'hA;
        normal.data = 32'h1234_5678;

        // Reset state, combinational mirror active during reset
        #2;
        check_val("rst_zvalid", 32'(zero_a.valid), 32'h1);
        check_val("rst_zstrb", 32'(zero_a.strb), 32'hA);
        check_val("rst_zdata", zero_a.data, 32'h0);
        tick();
        check_val("rst_det", 32'(det_a), 32'h0);
        check_val("rst_stk", 32'(stk_a), 32'h0);
        check_val("rst_cnt", 32'(cnt_a), 32'h0);
        check_val("rst_stall", 32'(st_a), 32'h0);
        rst_n = 1'b1;

        // Nominal traffic, readys agree
        enable = 1'b1;
        normal.strb = 4'hF;
        normal.data = 32'hDEAD_BEEF;
        tick();
        tick();
        check_val("nom_zvalid", 32'(zero_a.valid), 32'h1);
        check_val("nom_zstrb", 32'(zero_a.strb), 32'hF);
        check_val("nom_zdata", zero_a.data, 32'h0);
        check_val("nom_det", 32'(det_a), 32'h0);
        check_val("nom_stk", 32'(stk_a), 32'h0);
        check_val("nom_cnt", 32'(cnt_a), 32'h0);
        check_val("nom_stall", 32'(st_a), 32'h0);

        // Three mismatch cycles from MONITOR
        set_io(1'b1, 1'b1, 1'b0);
        tick();
        check_val("mm1_det", 32'(det_a), 32'h1);
        check_val("mm1_stk", 32'(stk_a), 32'h1);
        check_val("mm1_cnt", 32'(cnt_a), 32'h1);
        tick();
        check_val("mm2_det", 32'(det_a), 32'h1);
        check_val("mm2_cnt", 32'(cnt_a), 32'h2);
        tick();
        check_val("mm3_det", 32'(det_a), 32'h1);
        check_val("mm3_cnt", 32'(cnt_a), 32'h3);
        check_val("mm3_cnt_b", 32'(cnt_b), 32'h3);
        set_io(1'b1, 1'b1, 1'b1);
        tick();
        check_val("mm_end_det", 32'(det_a), 32'h0);
        check_val("mm_end_cnt", 32'(cnt_a), 32'h3);
        check_val("mm_end_stk", 32'(stk_a), 32'h1);

        // FAULTED keeps counting even with enable low
        enable = 1'b0;
        set_io(1'b1, 1'b1, 1'b0);
        tick();
        check_val("flt_det", 32'(det_a), 32'h1);
        check_val("flt_cnt", 32'(cnt_a), 32'h4);

        // Six more mismatches: dut_b saturates at 3, dut_a keeps counting
        for (int i = 0; i < 6; i++) tick();
        check_val("sat_cnt_a", 32'(cnt_a), 32'd10);
        check_val("sat_cnt_b", 32'(cnt_b), 32'h3);
        check_val("sat_stk_b", 32'(stk_b), 32'h1);

        // Clear in the same cycle as a mismatch
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("clr_cnt_a", 32'(cnt_a), 32'h0);
        check_val("clr_cnt_b", 32'(cnt_b), 32'h0);
        check_val("clr_stk", 32'(stk_a), 32'h0);
        check_val("clr_det", 32'(det_a), 32'h1);
        check_val("clr_stall", 32'(st_a), 32'h0);

        // Disabled: mismatching readys raise nothing
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("dis_det", 32'(det_a), 32'h0);
            check_val("dis_cnt", 32'(cnt_a), 32'h0);
            check_val("dis_stk", 32'(stk_a), 32'h0);
        end

        // Watchdog: handshake between stalls restarts the count
        set_io(1'b1, 1'b1, 1'b1);
        enable = 1'b1;
        tick();
        set_io(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        set_io(1'b1, 1'b1, 1'b1);
        tick();
        set_io(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check_val("wd_3_stall", 32'(st_a), 32'h0);
        tick();
        check_val("wd_4_stall_a", 32'(st_a), 32'(WD));
        check_val("wd_4_stall_b", 32'(st_b), 32'(WD));
        check_val("wd_4_cnt", 32'(cnt_a), 32'h0);

        // Stall fault leaves the FSM in FAULTED: a later mismatch still counts
        enable = 1'b0;
        set_io(1'b1, 1'b1, 1'b1);
        tick();
        set_io(1'b1, 1'b1, 1'b0);
        tick();
        check_val("wd_flt_det", 32'(det_a), 32'(WD));
        check_val("wd_flt_stall", 32'(st_a), 32'(WD));
        clear = 1'b1;
        set_io(1'b1, 1'b1, 1'b1);
        tick();
        clear = 1'b0;
        check_val("wd_clr_stall", 32'(st_a), 32'h0);
        check_val("wd_clr_cnt", 32'(cnt_a), 32'h0);

        // Asynchronous reset in the middle of a fault
        enable = 1'b1;
        tick();
        set_io(1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check_val("pre_rst_cnt", 32'(cnt_a), 32'h2);
        normal.valid = 1'b0;
        normal.strb = 4'h5;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_cnt", 32'(cnt_a), 32'h0);
        check_val("arst_stk", 32'(stk_a), 32'h0);
        check_val("arst_det", 32'(det_a), 32'h0);
        check_val("arst_zvalid", 32'(zero_a.valid), 32'h0);
        check_val("arst_zstrb", 32'(zero_a.strb), 32'h5);
        tick();
        rst_n = 1'b1;
        enable = 1'b0;
        set_io(1'b1, 1'b1, 1'b1);
        tick();
        check_val("post_rst_cnt", 32'(cnt_a), 32'h0);
        check_val("post_rst_stk", 32'(stk_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
